frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter_pkg.sv | 17 +
 rtl/frame_arbiter_if.sv | 20 ++
 rtl/frame_arbiter_idle_timer.sv | 28 ++
 rtl/frame_arbiter.sv | 135 +++++++++++++
 tb/tb_frame_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_arbiter_pkg.sv
// Shared types and constants for the frame arbiter: FSM states and source indices.
package frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_FLIP
  } arb_state_t;

  localparam int SRC_A = 0;
  localparam int SRC_B = 1;

  function automatic logic [1:0] src_onehot(input logic src);
    return (src == 1'(SRC_B)) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/frame_arbiter_if.sv
// Link between the frame arbiter and the data_loader: byte stream, frame handshake, abort.
interface frame_arbiter_if;

  logic [7:0] ldata;
  logic       lvalid;
  logic       loaded;
  logic       ready;
  logic       loader_abort;

  modport master (
    output ldata, lvalid, ready, loader_abort,
    input  loaded
  );

  modport slave (
    input  ldata, lvalid, ready, loader_abort,
    output loaded
  );

endinterface

// File: rtl/frame_arbiter_idle_timer.sv
// Counts idle cycles of the frame owner; expired is asserted on the cycle the limit is reached.
module idle_timer #(
  parameter int limit = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (limit < 2) ? 1 : $clog2(limit + 1);

  logic [W-1:0] count;

  assign expired = enable && !clear && (count == W'(limit - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      count <= '0;
    end else if (expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Arbitrates two byte sources into one data_loader frame and flips display banks.
// Optional owner-idle abort is built when FRAME_ARB_TIMEOUT_EN is defined.
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int timeout = 1000,
  parameter int dropw   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       a_data,
  input  logic             a_valid,
  input  logic [7:0]       b_data,
  input  logic             b_valid,
  frame_arbiter_if.master  loader,
  input  logic             frame_complete,
  output logic             mem_flip,
  output logic             frame_flipped,
  output logic [1:0]       grant,
  output logic [dropw-1:0] drop_count
);

  if (dropw < 2) begin : g_bad_dropw
    $error("frame_arbiter: dropw must be at least 2");
  end
  if (timeout < 1) begin : g_bad_timeout
    $error("frame_arbiter: timeout must be at least 1");
  end

  arb_state_t       state;
  logic             owner;
  logic             last_src;
  logic             owner_valid;
  logic             other_valid;
  logic [7:0]       owner_data;
  logic             idle_src;
  logic [1:0]       drop_inc;
  logic [dropw:0]   drop_sum;
  logic [dropw-1:0] drop_next;
  logic             timeout_hit;

  assign owner_valid = (owner == 1'(SRC_A)) ? a_valid : b_valid;
  assign other_valid = (owner == 1'(SRC_A)) ? b_valid : a_valid;
  assign owner_data  = (owner == 1'(SRC_A)) ? a_data  : b_data;

  // On a tie the source that did not win last time takes the frame.
  assign idle_src = (a_valid && b_valid) ? ~last_src :
                    (a_valid ? 1'(SRC_A) : 1'(SRC_B));

  always_comb begin
    drop_inc = 2'd0;
    case (state)
      IDLE:      drop_inc = {1'b0, a_valid & b_valid};
      LOAD:      drop_inc = {1'b0, other_valid};
      WAIT_FLIP: drop_inc = {1'b0, a_valid} + {1'b0, b_valid};
      default:   drop_inc = 2'd0;
    endcase
  end

  assign drop_sum  = {1'b0, drop_count} + {{(dropw-1){1'b0}}, drop_inc};
  assign drop_next = drop_sum[dropw] ? '1 : drop_sum[dropw-1:0];

`ifdef FRAME_ARB_TIMEOUT_EN
  idle_timer #(
    .limit(timeout)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state != LOAD) || owner_valid),
    .enable  (state == LOAD),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      owner               <= 1'(SRC_A);
      last_src            <= 1'(SRC_B);
      loader.ldata        <= 8'h00;
      loader.lvalid       <= 1'b0;
      loader.ready        <= 1'b1;
      loader.loader_abort <= 1'b0;
      mem_flip            <= 1'b0;
      frame_flipped       <= 1'b0;
      grant               <= 2'b00;
      drop_count          <= '0;
    end else begin
      loader.lvalid       <= 1'b0;
      loader.loader_abort <= 1'b0;
      frame_flipped       <= 1'b0;
      drop_count          <= drop_next;
      case (state)
        IDLE: begin
          if (a_valid || b_valid) begin
            owner         <= idle_src;
            last_src      <= idle_src;
            grant         <= src_onehot(idle_src);
            loader.ldata  <= (idle_src == 1'(SRC_B)) ? b_data : a_data;
            loader.lvalid <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (owner_valid) begin
            loader.ldata  <= owner_data;
            loader.lvalid <= 1'b1;
          end
          // A completed frame takes priority over an idle abort in the same cycle.
          if (loader.loaded) begin
            loader.ready <= 1'b0;
            grant        <= 2'b00;
            state        <= WAIT_FLIP;
          end else if (timeout_hit) begin
            loader.loader_abort <= 1'b1;
            grant               <= 2'b00;
            state               <= IDLE;
          end
        end
        WAIT_FLIP: begin
          if (frame_complete) begin
            mem_flip      <= ~mem_flip;
            frame_flipped <= 1'b1;
            loader.ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_arbiter.sv
// Self-checking bench for frame_arbiter: vector table, corner sequences and a randomized
// run against a behavioural model. Define FRAME_ARB_TIMEOUT_EN to exercise the idle abort.
module tb_frame_arbiter;

  localparam int TMO  = 16;
  localparam int DW   = 8;
  localparam int DMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    a_data, b_data;
  logic          a_valid, b_valid;
  logic          frame_complete;
  logic          mem_flip, frame_flipped;
  logic [1:0]    grant;
  logic [DW-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  frame_arbiter_if lif ();

  frame_arbiter #(
    .timeout(TMO),
    .dropw  (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .a_data         (a_data),
    .a_valid        (a_valid),
    .b_data         (b_data),
    .b_valid        (b_valid),
    .loader         (lif),
    .frame_complete (frame_complete),
    .mem_flip       (mem_flip),
    .frame_flipped  (frame_flipped),
    .grant          (grant),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: frame phase (0 open, 1 loading, 2 waiting for flip) and owner (0 none, 1 A, 2 B).
  int m_phase, m_owner, m_last, m_drops, m_flip, m_ready;
  int m_ldata, m_lvalid, m_ff, m_abort, m_idle;

  typedef struct {
    int av, ad, bv, bd, ld, fc;
    int e_ldata, e_lvalid, e_grant, e_ready, e_flip, e_ff, e_drop;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_owner = 0; m_last = 2; m_drops = 0; m_flip = 0; m_ready = 1;
    m_ldata = 0; m_lvalid = 0; m_ff = 0; m_abort = 0; m_idle = 0;
  endtask

  task automatic modelStep(input int av, input int ad, input int bv, input int bd,
                           input int ld, input int fc);
    int dropped;
    int win;
    int own_v;
    dropped  = 0;
    win      = 0;
    m_lvalid = 0;
    m_ff     = 0;
    m_abort  = 0;
    case (m_phase)
      0: begin
        if (av != 0 && bv != 0) begin
          win     = (m_last == 1) ? 2 : 1;
          dropped = 1;
        end else if (av != 0) win = 1;
        else if (bv != 0) win = 2;
        if (win != 0) begin
          m_owner  = win;
          m_last   = win;
          m_ldata  = (win == 1) ? ad : bd;
          m_lvalid = 1;
          m_phase  = 1;
          m_idle   = 0;
        end
      end
      1: begin
        own_v   = (m_owner == 1) ? av : bv;
        dropped = (m_owner == 1) ? bv : av;
        if (own_v != 0) begin
          m_ldata  = (m_owner == 1) ? ad : bd;
          m_lvalid = 1;
        end
        if (ld != 0) begin
          m_ready = 0;
          m_owner = 0;
          m_phase = 2;
        end
`ifdef FRAME_ARB_TIMEOUT_EN
        else begin
          if (own_v != 0) m_idle = 0;
          else m_idle++;
          if (m_idle == TMO) begin
            m_abort = 1;
            m_owner = 0;
            m_phase = 0;
          end
        end
`endif
      end
      default: begin
        dropped = av + bv;
        if (fc != 0) begin
          m_flip  = 1 - m_flip;
          m_ff    = 1;
          m_ready = 1;
          m_phase = 0;
        end
      end
    endcase
    m_drops = (m_drops + dropped > DMAX) ? DMAX : m_drops + dropped;
  endtask

  task automatic applyStimulus(input int av, input int ad, input int bv, input int bd,
                               input int ld, input int fc);
    a_valid        = av[0];
    a_data         = ad[7:0];
    b_valid        = bv[0];
    b_data         = bd[7:0];
    lif.loaded     = ld[0];
    frame_complete = fc[0];
    @(posedge clk);
    #1;
    modelStep(av, ad, bv, bd, ld, fc);
    a_valid        = 1'b0;
    b_valid        = 1'b0;
    lif.loaded     = 1'b0;
    frame_complete = 1'b0;
  endtask

  task automatic doReset();
    rst            = 1'b1;
    a_valid        = 1'b0;
    b_valid        = 1'b0;
    lif.loaded     = 1'b0;
    frame_complete = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".ldata"}, int'(lif.ldata), 0);
    checkOutput({tag, ".lvalid"}, int'(lif.lvalid), 0);
    checkOutput({tag, ".ready"}, int'(lif.ready), 1);
    checkOutput({tag, ".mem_flip"}, int'(mem_flip), 0);
    checkOutput({tag, ".frame_flipped"}, int'(frame_flipped), 0);
    checkOutput({tag, ".grant"}, int'(grant), 0);
    checkOutput({tag, ".loader_abort"}, int'(lif.loader_abort), 0);
    checkOutput({tag, ".drop_count"}, int'(drop_count), 0);
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".ldata"}, int'(lif.ldata), m_ldata);
    checkOutput({tag, ".lvalid"}, int'(lif.lvalid), m_lvalid);
    checkOutput({tag, ".grant"}, int'(grant), (m_owner == 1) ? 1 : (m_owner == 2) ? 2 : 0);
    checkOutput({tag, ".ready"}, int'(lif.ready), m_ready);
    checkOutput({tag, ".mem_flip"}, int'(mem_flip), m_flip);
    checkOutput({tag, ".frame_flipped"}, int'(frame_flipped), m_ff);
    checkOutput({tag, ".loader_abort"}, int'(lif.loader_abort), m_abort);
    checkOutput({tag, ".drop_count"}, int'(drop_count), m_drops);
  endtask

  initial begin
    int low_cnt, ff_cnt, lv_cnt, n, aborts;
    int av, bv, ld, fc, quiet;
    string tag;

    a_data = 8'h00;
    b_data = 8'h00;

    //           av ad     bv bd     ld fc  ldata  lv gr rdy flp ff drop
    vecs[0]  = '{1, 'h11, 0, 0,     0, 0, 'h11, 1, 1, 1, 0, 0, 0};
    vecs[1]  = '{1, 'h22, 0, 0,     0, 0, 'h22, 1, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0,    1, 'h33,  0, 0, 0,    0, 1, 1, 0, 0, 1};
    vecs[3]  = '{1, 'h44, 1, 'h55,  0, 0, 'h44, 1, 1, 1, 0, 0, 2};
    vecs[4]  = '{0, 0,    0, 0,     1, 0, 0,    0, 0, 0, 0, 0, 2};
    vecs[5]  = '{0, 0,    0, 0,     0, 0, 0,    0, 0, 0, 0, 0, 2};
    vecs[6]  = '{1, 'h66, 0, 0,     0, 0, 0,    0, 0, 0, 0, 0, 3};
    vecs[7]  = '{0, 0,    0, 0,     0, 1, 0,    0, 0, 1, 1, 1, 3};
    vecs[8]  = '{0, 0,    0, 0,     0, 0, 0,    0, 0, 1, 1, 0, 3};
    vecs[9]  = '{1, 'hAA, 1, 'hBB,  0, 0, 'hBB, 1, 2, 1, 1, 0, 4};
    vecs[10] = '{0, 0,    0, 0,     1, 1, 0,    0, 0, 0, 1, 0, 4};
    vecs[11] = '{0, 0,    0, 0,     0, 1, 0,    0, 0, 1, 0, 1, 4};
    vecs[12] = '{1, 'h01, 1, 'h02,  0, 0, 'h01, 1, 1, 1, 0, 0, 5};
    vecs[13] = '{0, 0,    0, 0,     0, 1, 0,    0, 1, 1, 0, 0, 5};
    vecs[14] = '{0, 0,    0, 0,     1, 0, 0,    0, 0, 0, 0, 0, 5};
    vecs[15] = '{1, 'h77, 1, 'h88,  0, 0, 0,    0, 0, 0, 0, 0, 7};
    vecs[16] = '{0, 0,    0, 0,     0, 1, 0,    0, 0, 1, 1, 1, 7};
    vecs[17] = '{0, 0,    0, 0,     1, 0, 0,    0, 0, 1, 1, 0, 7};

    doReset();
    checkReset("reset");

    applyStimulus(1, 'h05, 1, 'h06, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    doReset();
    checkReset("reset_mid_wait");
    applyStimulus(1, 'h05, 0, 0, 0, 0);
    doReset();
    checkReset("reset_mid_load");

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ld, vecs[i].fc);
      tag = $sformatf("vec%0d", i);
      if (vecs[i].e_lvalid != 0) checkOutput({tag, ".ldata"}, int'(lif.ldata), vecs[i].e_ldata);
      checkOutput({tag, ".lvalid"}, int'(lif.lvalid), vecs[i].e_lvalid);
      checkOutput({tag, ".grant"}, int'(grant), vecs[i].e_grant);
      checkOutput({tag, ".ready"}, int'(lif.ready), vecs[i].e_ready);
      checkOutput({tag, ".mem_flip"}, int'(mem_flip), vecs[i].e_flip);
      checkOutput({tag, ".frame_flipped"}, int'(frame_flipped), vecs[i].e_ff);
      checkOutput({tag, ".drop_count"}, int'(drop_count), vecs[i].e_drop);
    end

    doReset();
    applyStimulus(1, 'hAA, 1, 'hBB, 0, 0);
    checkOutput("tie_after_reset.grant", int'(grant), 1);
    checkOutput("tie_after_reset.ldata", int'(lif.ldata), 'hAA);
    checkOutput("tie_after_reset.drop_count", int'(drop_count), 1);

    doReset();
    applyStimulus(1, 'h10, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    low_cnt = (lif.ready == 1'b0) ? 1 : 0;
    ff_cnt  = 0;
    checkOutput("flip_seq.mem_flip_before", int'(mem_flip), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (lif.ready == 1'b0) low_cnt++;
      if (frame_flipped) ff_cnt++;
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("flip_seq.ready_low_cycles", low_cnt, 6);
    checkOutput("flip_seq.early_flip_pulses", ff_cnt, 0);
    checkOutput("flip_seq.ready_after", int'(lif.ready), 1);
    checkOutput("flip_seq.mem_flip_after", int'(mem_flip), 1);
    checkOutput("flip_seq.frame_flipped", int'(frame_flipped), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flip_seq.frame_flipped_end", int'(frame_flipped), 0);
    applyStimulus(1, 'h20, 0, 0, 0, 0);
    checkOutput("flip_seq.idle_grant", int'(grant), 1);
    checkOutput("flip_seq.idle_lvalid", int'(lif.lvalid), 1);

    doReset();
    applyStimulus(1, 'h30, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    lv_cnt = 0;
    for (int i = 0; i < 254; i++) begin
      applyStimulus(0, 0, 1, i, 0, 0);
      if (lif.lvalid) lv_cnt++;
    end
    checkOutput("sat.drop_254", int'(drop_count), 254);
    applyStimulus(1, 1, 1, 2, 0, 0);
    if (lif.lvalid) lv_cnt++;
    checkOutput("sat.double_drop", int'(drop_count), 255);
    for (int i = 0; i < 45; i++) begin
      applyStimulus(0, 0, 1, i, 0, 0);
      if (lif.lvalid) lv_cnt++;
    end
    checkOutput("sat.drop_final", int'(drop_count), 255);
    checkOutput("sat.lvalid_pulses", lv_cnt, 0);

    doReset();
    applyStimulus(1, 'h01, 0, 0, 0, 0);
    applyStimulus(1, 'h02, 0, 0, 0, 0);
    applyStimulus(1, 'h03, 0, 0, 0, 0);
`ifdef FRAME_ARB_TIMEOUT_EN
    n = 0;
    while (n <= 100) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      n++;
      if (lif.loader_abort) break;
    end
    checkOutput("timeout.cycles_to_abort", n, TMO);
    checkOutput("timeout.grant", int'(grant), 0);
    checkOutput("timeout.ready", int'(lif.ready), 1);
    checkOutput("timeout.mem_flip", int'(mem_flip), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("timeout.abort_width", int'(lif.loader_abort), 0);
`else
    aborts = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (lif.loader_abort) aborts++;
    end
    checkOutput("no_timeout.aborts", aborts, 0);
    checkOutput("no_timeout.grant", int'(grant), 1);
`endif

    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        quiet = ((cyc / 200) % 3 == 2) ? 1 : 0;
        av = (quiet != 0) ? int'($urandom_range(0, 31) == 0) : int'($urandom_range(0, 1));
        bv = (quiet != 0) ? int'($urandom_range(0, 31) == 0) : int'($urandom_range(0, 2) == 0);
        ld = int'($urandom_range(0, 15) == 0);
        fc = int'($urandom_range(0, 7) == 0);
        applyStimulus(av, int'($urandom_range(0, 255)), bv, int'($urandom_range(0, 255)), ld, fc);
      end
      checkAgainstModel($sformatf("rand%0d", cyc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
